fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the pipelined core: owns the program counter, drives the instruction-memory address, and hands `{pc, inst}` pairs to the decode stage through a 2-entry buffer with a valid/ready handshake. It replaces the free-running PC increment with a proper handshake, so memory wait states and decode back-pressure no longer drop instructions. It accepts a redirect (branch/jump target) from the execute stage, which flushes all in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `BUF_DEPTH`, default 2: decode buffer entries. Fixed at 2; other values are unsupported.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `memory_i_req`, out, 1: fetch request; `memory_i_addr` is valid while this is high.
- `memory_i_addr`, out, 32: fetch address, equal to the current PC.
- `memory_inst`, in, 32: instruction word for `memory_i_addr`.
- `memory_i_valid`, in, 1: `memory_inst` is valid this cycle for the current address.
- `redirect_valid`, in, 1: execute stage requests a PC change.
- `redirect_pc`, in, 32: new PC; bits [1:0] are ignored and treated as 0.
- `id_valid`, out, 1: the decode-side entry is valid.
- `id_ready`, in, 1: decode accepts the entry.
- `id_inst`, out, 32: instruction at the buffer head.
- `id_pc`, out, 32: PC of that instruction.

## Operation
- States:
  - IDLE: entered on reset. `memory_i_req` is 0. Moves to FETCH unconditionally on the first edge after `rst_n` rises.
  - FETCH: normal operation; the block never leaves it.
- Request: `memory_i_req = (state==FETCH) && !full && !redirect_valid`. `memory_i_addr = pc` at all times.
- Push:
  - Condition: `memory_i_req && memory_i_valid`.
  - Action: `{pc, memory_inst}` is written to the buffer tail and `pc <= pc + 4`.
  - The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Memory wait: while `memory_i_valid` is 0, the PC and request hold steady.
- Pop: on `id_valid && id_ready`, the head is removed.
- Push and pop in the same cycle are allowed when count is 0 or 1. When count==2, no push occurs (request is low), even if a pop happens that cycle.
- Redirect has top priority. In a cycle with `redirect_valid`=1:
  - `id_valid` is forced to 0 combinationally, so no pop occurs.
  - No push occurs, and `memory_inst` that cycle is discarded.
  - At the edge, the buffer is emptied and `pc <= {redirect_pc[31:2], 2'b00}`.
- Back-to-back redirects: the last one wins.
- `id_inst`/`id_pc` come from buffer head registers. When `id_valid`=0 they hold their previous values and are don't-care.
- Reset values: state=IDLE, `pc`=`RESET_PC`, buffer count=0, `memory_i_req`=0, `memory_i_addr`=`RESET_PC`, `id_valid`=0, `id_inst`=32'h0000_0013 (NOP), `id_pc`=0.
- Reset asserted mid-operation: every item above returns to its reset value immediately and asynchronously. In-flight entries are lost.

## Timing
- Latency: a push at edge N makes `id_valid`=1 in cycle N+1.
- Memory with `memory_i_valid` always 1 and decode always ready: one instruction per cycle in steady state; buffer count stays at 1.
- After `rst_n` rises:
  - cycle 0: IDLE.
  - cycle 1: first request, PC=`RESET_PC`.
  - cycle 2: `id_valid`=1 with `id_pc`=`RESET_PC`.
- Redirect at cycle R: `memory_i_addr`=target in cycle R+1; the first target instruction is at decode in R+2, given single-cycle memory.
- No combinational path from `id_ready` to `memory_i_req`. There is a path from `redirect_valid` to `memory_i_req` and to `id_valid`.

## Structure
- Shared package `core_pkg`:
  - `RESET_PC` default.
  - `INST_NOP` = 32'h0000_0013.
  - `fetch_entry_t` = `{pc[31:0], inst[31:0]}`.
  - Fetch state enum {IDLE, FETCH}.
- Sub-module `fetch_buffer`:
  - 2-entry synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, full, empty, head.
  - Async active-low reset; flush takes priority over push and pop.
- `fetch_stage` holds the FSM, the PC register, and the redirect logic.

## Test plan
- Reset, then `memory_i_valid`=1 and `id_ready`=1 with words 0xA0,0xA4,0xA8 at addresses 0,4,8 -> `id_pc` = 0,4,8 on consecutive cycles starting at cycle 2, matching `id_inst` each cycle.
- `id_ready`=0 for 5 cycles -> buffer holds PCs 0 and 4; `memory_i_req`=0 and `memory_i_addr`=8 while stalled; after release, 0,4,8 come out in order with no loss or duplicate.
- `memory_i_valid` low for 3 cycles at PC 0x10 -> `memory_i_addr` holds 0x10 and no entry is pushed; the next instruction after the gap has `id_pc`=0x10.
- Buffer holding PCs 0x20 and 0x24 when `redirect_valid`=1 with `redirect_pc`=0x103 -> `id_valid`=0 that cycle, buffer empty after the edge, next `memory_i_addr`=0x100, next `id_pc`=0x100.
- Redirect to 32'hFFFF_FFFC, then 2 fetches -> `id_pc` = 0xFFFF_FFFC, then 0x0000_0000.
- `rst_n` pulsed low mid-stream with count=2 -> `id_valid`=0, `memory_i_req`=0, `memory_i_addr`=`RESET_PC` immediately, without waiting for a clock edge; refetch resumes from `RESET_PC`.

Source files
------------

// File: rtl/core_pkg.sv
// Types and constants shared by the front-end pipeline stages.
package core_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        IDLE,
        FETCH
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between fetch and decode. Flush overrides push/pop, and the
// head register keeps its last contents once drained.
module fetch_buffer
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam fetch_entry_t RESET_ENTRY = '{pc: 32'h0000_0000, inst: INST_NOP};

    logic [1:0]   count_q, count_d;
    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic         do_push, do_pop;

    assign full    = (count_q == 2'(DEPTH));
    assign empty   = (count_q == 2'd0);
    assign head    = head_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = din;
                    end else begin
                        tail_d = din;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Only shift when a second entry exists; a lone head stays visible.
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop is only possible with exactly one entry.
                    head_d = din;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= RESET_ENTRY;
            tail_q  <= RESET_ENTRY;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, request/redirect control, and the decode
// buffer handshake.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        memory_i_req,
    output logic [31:0] memory_i_addr,
    input  logic [31:0] memory_inst,
    input  logic        memory_i_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         buf_full, buf_empty;
    logic         push, pop;
    fetch_entry_t push_entry, head_entry;
    logic         unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Redirect suppresses both sides of the buffer within the same cycle.
    assign memory_i_req  = (state_q == FETCH) && !buf_full && !redirect_valid;
    assign memory_i_addr = pc_q;
    assign push          = memory_i_req && memory_i_valid;
    assign id_valid      = !buf_empty && !redirect_valid;
    assign pop           = id_valid && id_ready;
    assign push_entry    = '{pc: pc_q, inst: memory_inst};
    assign id_inst       = head_entry.inst;
    assign id_pc         = head_entry.pc;

    always_comb begin
        state_d = FETCH;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (head_entry)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the memory returns (address + 0xA0) as the word.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        memory_i_req;
    logic [31:0] memory_i_addr;
    logic [31:0] memory_inst;
    logic        memory_i_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int errors = 0;
    int checks = 0;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memory_i_req   (memory_i_req),
        .memory_i_addr  (memory_i_addr),
        .memory_inst    (memory_inst),
        .memory_i_valid (memory_i_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memory_inst = memory_i_addr + 32'h0000_00A0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_inst"}, id_inst, inst);
    endtask

    initial begin
        rst_n          = 1'b0;
        memory_i_valid = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'd0, memory_i_req}, 32'd0);
        chk("rst_addr", memory_i_addr, 32'h0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_inst", id_inst, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'h0);

        // Streaming: cycle 0 idle, cycle 1 request, cycle 2 first entry.
        rst_n          = 1'b1;
        memory_i_valid = 1'b1;
        id_ready       = 1'b1;
        #1;
        chk("c0_req", {31'd0, memory_i_req}, 32'd0);
        tick();
        chk("c1_req", {31'd0, memory_i_req}, 32'd1);
        chk("c1_addr", memory_i_addr, 32'h0);
        chk("c1_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk_head("s0", 32'h0, 32'hA0);
        tick();
        chk_head("s4", 32'h4, 32'hA4);
        tick();
        chk_head("s8", 32'h8, 32'hA8);

        // Back-pressure from a fresh reset: buffer fills with 0 and 4.
        rst_n    = 1'b0;
        id_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("bp_c2_pc", id_pc, 32'h0);
        tick();
        chk("bp_req", {31'd0, memory_i_req}, 32'd0);
        chk("bp_addr", memory_i_addr, 32'h8);
        tick();
        tick();
        tick();
        chk("bp_req_late", {31'd0, memory_i_req}, 32'd0);
        chk("bp_addr_late", memory_i_addr, 32'h8);
        chk_head("bp_hold", 32'h0, 32'hA0);
        id_ready = 1'b1;
        tick();
        chk_head("bp_out4", 32'h4, 32'hA4);
        chk("bp_req_rel", {31'd0, memory_i_req}, 32'd1);
        tick();
        chk_head("bp_out8", 32'h8, 32'hA8);
        tick();
        chk_head("bp_outC", 32'hC, 32'hAC);
        chk("ws_addr0", memory_i_addr, 32'h10);

        // Memory wait at 0x10 for three cycles.
        memory_i_valid = 1'b0;
        tick();
        chk("ws_addr1", memory_i_addr, 32'h10);
        chk("ws_valid1", {31'd0, id_valid}, 32'd0);
        tick();
        chk("ws_addr2", memory_i_addr, 32'h10);
        chk("ws_valid2", {31'd0, id_valid}, 32'd0);
        tick();
        chk("ws_addr3", memory_i_addr, 32'h10);
        chk("ws_valid3", {31'd0, id_valid}, 32'd0);
        memory_i_valid = 1'b1;
        tick();
        chk_head("ws_after", 32'h10, 32'hB0);

        // Fill with 0x20/0x24, then redirect to 0x103.
        tick();
        tick();
        tick();
        tick();
        chk_head("rd_h20", 32'h20, 32'hC0);
        id_ready = 1'b0;
        tick();
        chk("rd_full_req", {31'd0, memory_i_req}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("rd_valid_forced", {31'd0, id_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #1;
        chk("rd_empty", {31'd0, id_valid}, 32'd0);
        chk("rd_addr", memory_i_addr, 32'h100);
        chk("rd_req", {31'd0, memory_i_req}, 32'd1);
        tick();
        chk_head("rd_first", 32'h100, 32'h1A0);

        // Back-to-back redirects, the later one lands at the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", memory_i_addr, 32'hFFFF_FFFC);
        tick();
        chk_head("wrap_top", 32'hFFFF_FFFC, 32'h0000_009C);
        tick();
        chk_head("wrap_zero", 32'h0, 32'hA0);

        // Fill to two entries, then assert reset between clock edges.
        id_ready = 1'b0;
        tick();
        chk("ar_full_req", {31'd0, memory_i_req}, 32'd0);
        chk("ar_addr_pre", memory_i_addr, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, id_valid}, 32'd0);
        chk("ar_req", {31'd0, memory_i_req}, 32'd0);
        chk("ar_addr", memory_i_addr, 32'h0);
        chk("ar_inst", id_inst, 32'h0000_0013);
        chk("ar_pc", id_pc, 32'h0);
        tick();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        tick();
        chk("ar_c1_addr", memory_i_addr, 32'h0);
        chk("ar_c1_req", {31'd0, memory_i_req}, 32'd1);
        tick();
        chk_head("ar_refetch", 32'h0, 32'hA0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
